// File: rtl/shift_pkg.sv
// Shared definitions for the shift/rotate execution stage.
//   op_t    : operation encodings presented on shift_seq.op
//   state_t : sequencer states
//   *_DEF   : default datapath width, shift-amount width and coarse step size
package shift_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int SHW_DEF   = 5;
    localparam int STEP_DEF  = 4;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One combinational shift/rotate step of either 1 bit or STEP bits.
// Ports:
//   op      : operation (SLL/SRL/SRA/ROR)
//   value   : current working value
//   sign    : sign bit of the original operand (SRA fill)
//   coarse  : 1 = move STEP bits, 0 = move 1 bit
//   nxt     : value after this step
//   out_bit : last bit to leave the word in this step (ROR: new MSB)
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int STEP  = STEP_DEF
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] value,
    input  logic             sign,
    input  logic             coarse,
    output logic [WIDTH-1:0] nxt,
    output logic             out_bit
);

    always_comb begin
        nxt     = value;
        out_bit = 1'b0;
        if (coarse) begin
            // The bit nearest the stay-behind side leaves the word last.
            case (op)
                OP_SLL: begin
                    nxt     = {value[WIDTH-STEP-1:0], {STEP{1'b0}}};
                    out_bit = value[WIDTH-STEP];
                end
                OP_SRL: begin
                    nxt     = {{STEP{1'b0}}, value[WIDTH-1:STEP]};
                    out_bit = value[STEP-1];
                end
                OP_SRA: begin
                    nxt     = {{STEP{sign}}, value[WIDTH-1:STEP]};
                    out_bit = value[STEP-1];
                end
                default: begin
                    nxt     = {value[STEP-1:0], value[WIDTH-1:STEP]};
                    out_bit = value[STEP-1];
                end
            endcase
        end else begin
            case (op)
                OP_SLL: begin
                    nxt     = {value[WIDTH-2:0], 1'b0};
                    out_bit = value[WIDTH-1];
                end
                OP_SRL: begin
                    nxt     = {1'b0, value[WIDTH-1:1]};
                    out_bit = value[0];
                end
                OP_SRA: begin
                    nxt     = {sign, value[WIDTH-1:1]};
                    out_bit = value[0];
                end
                default: begin
                    nxt     = {value[0], value[WIDTH-1:1]};
                    out_bit = value[0];
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift/rotate execution stage.
// A request (op, a_in, shamt) is taken over in_valid/in_ready while IDLE.
// The effective count is worked off in STEP-bit coarse steps while at least
// STEP remain, then in 1-bit steps. The result with zero/carry flags is held
// in DONE until out_ready.
// Optional build macro SHIFT_SEQ_FAST_EN: a barrel shifter performs the whole
// shift in a single SHIFT cycle; results and flags are identical.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : request handshake (in_ready high only in IDLE)
//   op, a_in, shamt     : operation, operand, shift amount
//   out_valid, out_ready: result handshake (out_valid high only in DONE)
//   result, zero, carry : shifted value, result==0, last bit shifted out
module shift_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF,
    parameter int STEP  = STEP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    op_t              op_q, op_nxt;
    logic [WIDTH-1:0] val_q, val_nxt;
    logic             sign_q, sign_nxt;
    logic [CW-1:0]    cnt_q, cnt_nxt;
    logic             carry_q, carry_nxt;

    logic [CW-1:0]    eff_cnt;
    logic [WIDTH-1:0] mv_val;
    logic             mv_bit;
    logic [CW-1:0]    mv_dec;

    // Rotates wrap, so only shamt mod WIDTH matters; shifts saturate at WIDTH
    // (everything gone), which keeps the step count bounded.
    always_comb begin
        if (op_t'(op) == OP_ROR)
            eff_cnt = CW'(int'(shamt) % WIDTH);
        else if (int'(shamt) >= WIDTH)
            eff_cnt = CW'(WIDTH);
        else
            eff_cnt = CW'(shamt);
    end

`ifdef SHIFT_SEQ_FAST_EN
    // Extended by one bit so the bit leaving the word lands in the extra
    // position; this also yields carry 0 naturally for a count of 0.
    logic [WIDTH:0] ext;

    always_comb begin
        ext    = '0;
        mv_val = val_q;
        mv_bit = 1'b0;
        case (op_q)
            OP_SLL: begin
                ext    = {1'b0, val_q} << cnt_q;
                mv_val = ext[WIDTH-1:0];
                mv_bit = ext[WIDTH];
            end
            OP_SRL: begin
                ext    = {val_q, 1'b0} >> cnt_q;
                mv_val = ext[WIDTH:1];
                mv_bit = ext[0];
            end
            OP_SRA: begin
                ext    = (WIDTH+1)'($signed({sign_q, val_q[WIDTH-2:0], 1'b0}) >>> cnt_q);
                mv_val = ext[WIDTH:1];
                mv_bit = ext[0];
            end
            default: begin
                mv_val = (val_q >> cnt_q) | (val_q << (CW'(WIDTH) - cnt_q));
                mv_bit = mv_val[WIDTH-1];
            end
        endcase
    end

    // Whole count consumed in one step.
    assign mv_dec = cnt_q;
`else
    logic coarse;

    assign coarse = (cnt_q >= CW'(STEP));
    assign mv_dec = coarse ? CW'(STEP) : CW'(1);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .op      (op_q),
        .value   (val_q),
        .sign    (sign_q),
        .coarse  (coarse),
        .nxt     (mv_val),
        .out_bit (mv_bit)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= OP_SLL;
            val_q   <= '0;
            sign_q  <= 1'b0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            op_q    <= op_nxt;
            val_q   <= val_nxt;
            sign_q  <= sign_nxt;
            cnt_q   <= cnt_nxt;
            carry_q <= carry_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        val_nxt   = val_q;
        sign_nxt  = sign_q;
        cnt_nxt   = cnt_q;
        carry_nxt = carry_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    op_nxt    = op_t'(op);
                    val_nxt   = a_in;
                    sign_nxt  = a_in[WIDTH-1];
                    cnt_nxt   = eff_cnt;
                    carry_nxt = 1'b0;
                    // Count 0 skips SHIFT: operand passes through unchanged.
                    state_nxt = (eff_cnt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                val_nxt   = mv_val;
                carry_nxt = mv_bit;
                cnt_nxt   = cnt_q - mv_dec;
                if (cnt_q == mv_dec)
                    state_nxt = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = val_q;
    assign carry     = carry_q;
    // Gated so the flag reads 0 out of reset even though result is 0 then.
    assign zero      = out_valid && (val_q == '0);

endmodule
